ctrl_decode_stage: RTL and testbench



---
 rtl/ctrl_decode_stage_pkg.sv | 69 ++++++
 rtl/ctrl_decode_stage_if.sv | 58 +++++
 rtl/ctrl_decode_comb.sv | 92 +++++++++
 rtl/ctrl_decode_stage.sv | 118 +++++++++++
 tb/tb_ctrl_decode_stage.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_decode_stage_pkg.sv
// Shared decode definitions for the ID stage: opcodes, functs, ALU codes and the control word.
// Optional build macro JAL_EN adds jal/jr; the fields exist in both builds.
package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_RTYPE = 4'b0010;
  localparam logic [3:0] ALU_ADDI  = 4'b0011;
  localparam logic [3:0] ALU_ANDI  = 4'b0100;
  localparam logic [3:0] ALU_ORI   = 4'b0101;
  localparam logic [3:0] ALU_SLTI  = 4'b0110;
  localparam logic [3:0] ALU_XORI  = 4'b0111;
  localparam logic [3:0] ALU_SLL   = 4'b1000;
  localparam logic [3:0] ALU_SRL   = 4'b1001;
  localparam logic [3:0] ALU_ROTR  = 4'b1011;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_BEQ  = 2'b01,
    BR_BNE  = 2'b10,
    BR_BGTZ = 2'b11
  } br_type_t;

  typedef struct packed {
    logic       reg_dst;
    br_type_t   branch_type;
    logic       jump;
    logic       mem_to_read;
    logic       mem_to_reg;
    logic       mem_to_write;
    logic       alu_src_a;
    logic       alu_src_b;
    logic       reg_write;
    logic       link;
    logic       jr;
    logic [3:0] alu_op;
    logic       illegal;
  } ctrl_word_t;

  function automatic logic [3:0] imm_alu_op(input logic [5:0] op);
    case (op)
      OP_ADDI: return ALU_ADDI;
      OP_ANDI: return ALU_ANDI;
      OP_ORI:  return ALU_ORI;
      OP_SLTI: return ALU_SLTI;
      OP_XORI: return ALU_XORI;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode_stage_if.sv
// IF/ID-side inputs and ID/EX-side outputs of the decode stage.
// With JAL_EN defined the link_o/jr_o signals are present.
interface ctrl_decode_stage_if #(
  parameter int REG_ADDR_W = 5,
  parameter int ALU_OP_W   = 4,
  parameter int CNT_W      = 16
) ();
  logic                  valid_i;
  logic [31:0]           instr_i;
  logic                  stall_i;
  logic                  flush_i;
  logic                  stall_o;
  logic                  valid_o;
  logic [REG_ADDR_W-1:0] rs_o;
  logic [REG_ADDR_W-1:0] rt_o;
  logic [REG_ADDR_W-1:0] dst_o;
  logic [1:0]            branchType_o;
  logic                  jump_o;
  logic                  memToRead_o;
  logic                  memToReg_o;
  logic                  memToWrite_o;
  logic                  aluSrcA_o;
  logic                  aluSrcB_o;
  logic                  regWrite_o;
  logic [ALU_OP_W-1:0]   aluOp_o;
  logic                  illegal_o;
  logic [CNT_W-1:0]      hazard_cnt_o;
`ifdef JAL_EN
  logic                  link_o;
  logic                  jr_o;

  modport master (
    output valid_i, instr_i, stall_i, flush_i,
    input  stall_o, valid_o, rs_o, rt_o, dst_o, branchType_o, jump_o, memToRead_o,
           memToReg_o, memToWrite_o, aluSrcA_o, aluSrcB_o, regWrite_o, aluOp_o,
           illegal_o, hazard_cnt_o, link_o, jr_o
  );
  modport slave (
    input  valid_i, instr_i, stall_i, flush_i,
    output stall_o, valid_o, rs_o, rt_o, dst_o, branchType_o, jump_o, memToRead_o,
           memToReg_o, memToWrite_o, aluSrcA_o, aluSrcB_o, regWrite_o, aluOp_o,
           illegal_o, hazard_cnt_o, link_o, jr_o
  );
`else
  modport master (
    output valid_i, instr_i, stall_i, flush_i,
    input  stall_o, valid_o, rs_o, rt_o, dst_o, branchType_o, jump_o, memToRead_o,
           memToReg_o, memToWrite_o, aluSrcA_o, aluSrcB_o, regWrite_o, aluOp_o,
           illegal_o, hazard_cnt_o
  );
  modport slave (
    input  valid_i, instr_i, stall_i, flush_i,
    output stall_o, valid_o, rs_o, rt_o, dst_o, branchType_o, jump_o, memToRead_o,
           memToReg_o, memToWrite_o, aluSrcA_o, aluSrcB_o, regWrite_o, aluOp_o,
           illegal_o, hazard_cnt_o
  );
`endif
endinterface

// File: rtl/ctrl_decode_comb.sv
// Pure combinational instruction -> control word decoder, shared with the single-cycle core.
// JAL_EN adds jal and jr decoding.
module ctrl_decode_comb
  import ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output ctrl_word_t  ctrl,
  output logic        uses_rt
);

  logic [5:0] op;
  logic [5:0] funct;
  logic       unused_bits;

  assign op          = instr[31:26];
  assign funct       = instr[5:0];
  assign unused_bits = ^{instr[25:22], instr[20:6]};

  // opcode/funct decode; every field starts at zero so unlisted signals stay low
  always_comb begin
    ctrl    = '0;
    uses_rt = 1'b0;
    case (op)
      OP_RTYPE: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALU_RTYPE;
        uses_rt        = 1'b1;
        case (funct)
          FN_SLL: begin
            ctrl.alu_op    = ALU_SLL;
            ctrl.alu_src_a = 1'b1;
          end
          FN_SRL: begin
            ctrl.alu_op    = instr[21] ? ALU_ROTR : ALU_SRL;
            ctrl.alu_src_a = 1'b1;
          end
`ifdef JAL_EN
          FN_JR: begin
            ctrl.jump      = 1'b1;
            ctrl.reg_write = 1'b0;
            ctrl.jr        = 1'b1;
          end
`endif
          default: ctrl.alu_op = ALU_RTYPE;
        endcase
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_XORI: begin
        ctrl.alu_op    = imm_alu_op(op);
        ctrl.alu_src_b = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OP_LW: begin
        ctrl.alu_op      = ALU_ADD;
        ctrl.alu_src_b   = 1'b1;
        ctrl.mem_to_read = 1'b1;
        ctrl.mem_to_reg  = 1'b1;
        ctrl.reg_write   = 1'b1;
      end
      OP_SW: begin
        ctrl.alu_op       = ALU_ADD;
        ctrl.alu_src_b    = 1'b1;
        ctrl.mem_to_write = 1'b1;
        uses_rt           = 1'b1;
      end
      OP_BEQ: begin
        ctrl.alu_op      = ALU_SUB;
        ctrl.branch_type = BR_BEQ;
        uses_rt          = 1'b1;
      end
      OP_BNE: begin
        ctrl.alu_op      = ALU_SUB;
        ctrl.branch_type = BR_BNE;
        uses_rt          = 1'b1;
      end
      OP_BGTZ: begin
        ctrl.alu_op      = ALU_SUB;
        ctrl.branch_type = BR_BGTZ;
      end
      OP_J: ctrl.jump = 1'b1;
`ifdef JAL_EN
      OP_JAL: begin
        ctrl.jump      = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.link      = 1'b1;
      end
`endif
      default: ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ctrl_decode_stage.sv
// ID stage: decode, load-use hazard detection, stall/flush priority and the ID/EX register.
// JAL_EN adds jal/jr support and the link_o/jr_o outputs.
module ctrl_decode_stage
  import ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int ALU_OP_W   = 4,
  parameter int CNT_W      = 16
) (
  input logic                 clk_i,
  input logic                 rst_i,
  ctrl_decode_stage_if.slave  bus
);

  ctrl_word_t            dec;
  ctrl_word_t            load_word;
  ctrl_word_t            word_q;
  logic                  uses_rt;
  logic                  hazard;
  logic                  valid_q;
  logic [REG_ADDR_W-1:0] rs, rt, rd, dst;
  logic [REG_ADDR_W-1:0] rs_q, rt_q, dst_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  unused_bits;

  ctrl_decode_comb u_dec (
    .instr   (bus.instr_i),
    .ctrl    (dec),
    .uses_rt (uses_rt)
  );

  assign rs = REG_ADDR_W'(bus.instr_i[25:21]);
  assign rt = REG_ADDR_W'(bus.instr_i[20:16]);
  assign rd = REG_ADDR_W'(bus.instr_i[15:11]);

  // destination resolution and the word loaded when nothing blocks the slot
  always_comb begin
    if (dec.link) begin
      dst = REG_ADDR_W'(5'd31);
    end else if (dec.reg_dst) begin
      dst = rd;
    end else begin
      dst = rt;
    end
    load_word = '0;
    if (bus.valid_i) begin
      load_word = dec;
      if (dst == '0) begin
        load_word.reg_write = 1'b0;
      end else begin
        load_word.reg_write = dec.reg_write;
      end
    end else begin
      load_word = '0;
    end
  end

  assign hazard = valid_q && word_q.mem_to_read && (dst_q != '0) && bus.valid_i &&
                  ((dst_q == rs) || (uses_rt && (dst_q == rt)));

  assign bus.stall_o = bus.stall_i | (hazard & ~bus.flush_i);

  // ID/EX register: reset > stall > flush > hazard bubble > load
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      word_q  <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
    end else if (bus.stall_i) begin
      valid_q <= valid_q;
      word_q  <= word_q;
      rs_q    <= rs_q;
      rt_q    <= rt_q;
      dst_q   <= dst_q;
      cnt_q   <= cnt_q;
    end else if (bus.flush_i || hazard) begin
      valid_q <= 1'b0;
      word_q  <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      dst_q   <= '0;
      if (!bus.flush_i && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end else begin
      valid_q <= bus.valid_i;
      word_q  <= load_word;
      rs_q    <= bus.valid_i ? rs  : '0;
      rt_q    <= bus.valid_i ? rt  : '0;
      dst_q   <= bus.valid_i ? dst : '0;
    end
  end

  assign bus.valid_o      = valid_q;
  assign bus.rs_o         = rs_q;
  assign bus.rt_o         = rt_q;
  assign bus.dst_o        = dst_q;
  assign bus.branchType_o = word_q.branch_type;
  assign bus.jump_o       = word_q.jump;
  assign bus.memToRead_o  = word_q.mem_to_read;
  assign bus.memToReg_o   = word_q.mem_to_reg;
  assign bus.memToWrite_o = word_q.mem_to_write;
  assign bus.aluSrcA_o    = word_q.alu_src_a;
  assign bus.aluSrcB_o    = word_q.alu_src_b;
  assign bus.regWrite_o   = word_q.reg_write;
  assign bus.aluOp_o      = ALU_OP_W'(word_q.alu_op);
  assign bus.illegal_o    = word_q.illegal;
  assign bus.hazard_cnt_o = cnt_q;
`ifdef JAL_EN
  assign bus.link_o       = word_q.link;
  assign bus.jr_o         = word_q.jr;
`endif
  assign unused_bits      = ^{word_q.reg_dst, word_q.link, word_q.jr};

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Randomized scoreboard bench for ctrl_decode_stage with a spec-level reference model.
// Build with JAL_EN defined to cover jal/jr as well.
module tb_ctrl_decode_stage;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dst;
    logic [1:0]  br;
    logic        jump;
    logic        mrd;
    logic        mreg;
    logic        mwr;
    logic        srca;
    logic        srcb;
    logic        regw;
    logic [3:0]  alu;
    logic        illegal;
    logic        link;
    logic        jr;
    logic [15:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];
  exp_t m;

  ctrl_decode_stage_if #(.REG_ADDR_W(5), .ALU_OP_W(4), .CNT_W(16)) bus ();

  ctrl_decode_stage #(.REG_ADDR_W(5), .ALU_OP_W(4), .CNT_W(16)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference decode written straight from the opcode table.
  function automatic void ref_decode(input logic [31:0] ins, output exp_t w, output bit urt);
    logic [5:0] op;
    logic [5:0] fn;
    bit rdst;
    bit lnk;
    op = ins[31:26];
    fn = ins[5:0];
    w = '0;
    urt = 1'b0;
    rdst = 1'b0;
    lnk = 1'b0;
    if (op == 6'd0) begin
      urt = 1'b1; rdst = 1'b1; w.regw = 1'b1; w.alu = 4'd2;
      if (fn == 6'd0) begin
        w.alu = 4'd8; w.srca = 1'b1;
      end else if (fn == 6'd2) begin
        w.alu = ins[21] ? 4'd11 : 4'd9; w.srca = 1'b1;
      end
`ifdef JAL_EN
      else if (fn == 6'd8) begin
        w.jump = 1'b1; w.regw = 1'b0; w.jr = 1'b1;
      end
`endif
    end else if (op == 6'd8)  begin w.alu = 4'd3; w.srcb = 1'b1; w.regw = 1'b1; end
    else if (op == 6'd12) begin w.alu = 4'd4; w.srcb = 1'b1; w.regw = 1'b1; end
    else if (op == 6'd13) begin w.alu = 4'd5; w.srcb = 1'b1; w.regw = 1'b1; end
    else if (op == 6'd10) begin w.alu = 4'd6; w.srcb = 1'b1; w.regw = 1'b1; end
    else if (op == 6'd14) begin w.alu = 4'd7; w.srcb = 1'b1; w.regw = 1'b1; end
    else if (op == 6'd35) begin w.srcb = 1'b1; w.mrd = 1'b1; w.mreg = 1'b1; w.regw = 1'b1; end
    else if (op == 6'd43) begin w.srcb = 1'b1; w.mwr = 1'b1; urt = 1'b1; end
    else if (op == 6'd4)  begin w.alu = 4'd1; w.br = 2'd1; urt = 1'b1; end
    else if (op == 6'd5)  begin w.alu = 4'd1; w.br = 2'd2; urt = 1'b1; end
    else if (op == 6'd7)  begin w.alu = 4'd1; w.br = 2'd3; end
    else if (op == 6'd2)  begin w.jump = 1'b1; end
`ifdef JAL_EN
    else if (op == 6'd3)  begin w.jump = 1'b1; w.regw = 1'b1; w.link = 1'b1; lnk = 1'b1; end
`endif
    else w.illegal = 1'b1;
    w.rs = ins[25:21];
    w.rt = ins[20:16];
    w.dst = lnk ? 5'd31 : (rdst ? ins[15:11] : ins[20:16]);
    if (w.dst == 5'd0) w.regw = 1'b0;
  endfunction

  // Drive one cycle of inputs, check the combinational stall, push the expected ID/EX state.
  task automatic step(input logic r, input logic v, input logic [31:0] ins,
                      input logic st, input logic fl);
    exp_t d;
    bit urt;
    bit haz;
    logic exp_stall;
    logic [15:0] c;
    @(negedge clk);
    rst = r;
    bus.valid_i = v;
    bus.instr_i = ins;
    bus.stall_i = st;
    bus.flush_i = fl;
    #1;
    ref_decode(ins, d, urt);
    haz = m.valid && m.mrd && (m.dst != 5'd0) && v &&
          ((m.dst == d.rs) || (urt && (m.dst == d.rt)));
    exp_stall = st | (haz & ~fl);
    tests++;
    if (bus.stall_o !== exp_stall) begin
      fails++;
      $display("FAIL stall_o instr=%h got %b want %b", ins, bus.stall_o, exp_stall);
    end
    c = m.cnt;
    if (r) begin
      m = '0;
    end else if (st) begin
      m = m;
    end else if (fl || haz) begin
      m = '0;
      m.cnt = (haz && !fl && c != 16'hFFFF) ? c + 16'd1 : c;
    end else if (!v) begin
      m = '0;
      m.cnt = c;
    end else begin
      m = d;
      m.valid = 1'b1;
      m.cnt = c;
    end
    sb.push_back(m);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] op;
    logic [5:0] fn;
    case ($urandom_range(0, 14))
      0, 1:    op = 6'd0;
      2:       op = 6'd8;
      3:       op = 6'd12;
      4:       op = 6'd13;
      5:       op = 6'd10;
      6:       op = 6'd14;
      7, 8, 9: op = 6'd35;
      10:      op = 6'd43;
      11:      op = 6'd4 + 6'($urandom_range(0, 1));
      12:      op = 6'd7;
      13:      op = 6'd2 + 6'($urandom_range(0, 1));
      default: op = 6'($urandom_range(48, 63));
    endcase
    case ($urandom_range(0, 3))
      0:       fn = 6'd0;
      1:       fn = 6'd2;
      2:       fn = 6'd8;
      default: fn = 6'd32;
    endcase
    return {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), fn};
  endfunction

  // Monitor: the ID/EX register updates on every edge, compare against the queue head.
  initial begin
    exp_t e;
    exp_t a;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        a = '0;
        a.valid = bus.valid_o;     a.rs = bus.rs_o;           a.rt = bus.rt_o;
        a.dst = bus.dst_o;         a.br = bus.branchType_o;   a.jump = bus.jump_o;
        a.mrd = bus.memToRead_o;   a.mreg = bus.memToReg_o;   a.mwr = bus.memToWrite_o;
        a.srca = bus.aluSrcA_o;    a.srcb = bus.aluSrcB_o;    a.regw = bus.regWrite_o;
        a.alu = bus.aluOp_o;       a.illegal = bus.illegal_o; a.cnt = bus.hazard_cnt_o;
`ifdef JAL_EN
        a.link = bus.link_o;       a.jr = bus.jr_o;
`endif
        tests++;
        if (a !== e) begin
          fails++;
          $display("FAIL idex got %h want %h (instr %h)", a, e, bus.instr_i);
        end
      end
    end
  end

  initial begin
    m = '0;
    bus.valid_i = 1'b0;
    bus.instr_i = 32'd0;
    bus.stall_i = 1'b0;
    bus.flush_i = 1'b0;
    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h20080005, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h8D090000, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h01285020, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h01285020, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h8D090000, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h01285020, 1'b0, 1'b1);
    step(1'b0, 1'b1, 32'h11090003, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'h20080005, 1'b1, 1'b0);
    step(1'b0, 1'b1, 32'h20080005, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'hFC000000, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h20000001, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h00200A82, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h20080005, 1'b0, 1'b0);
`ifdef JAL_EN
    step(1'b0, 1'b1, 32'h0C000010, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h8D090000, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h01200008, 1'b0, 1'b0);
`endif
    step(1'b0, 1'b1, 32'h8D090000, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h01285020, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h01285020, 1'b0, 1'b0);
    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) < 85) ? 1'b1 : 1'b0,
           rand_instr(),
           ($urandom_range(0, 99) < 15) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) < 10) ? 1'b1 : 1'b0);
    end
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain got %0d pending want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
